// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline encodings: ALU ops, forward selects, result sources, bubble values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  // ALU operation encodings carried in ALUControl
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLT = 5'b00101;

  // Hazard-unit forward selects; 2'b11 is unused and falls back to the register value
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  // Writeback result source encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // funct3 value that matches no branch condition, so a bubble can never branch
  localparam logic [2:0] BUBBLE_FUNCT3   = 3'b010;
  localparam logic [4:0] BUBBLE_ALU_CTRL = ALU_ADD;

  // Control bundle travelling down the pipe alongside the data
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [4:0] alu_control;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{
    reg_write:   1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    alu_src:     1'b0,
    result_src:  RES_ALU,
    alu_control: BUBBLE_ALU_CTRL,
    funct3:      BUBBLE_FUNCT3
  };

endpackage

// File: rtl/fwd_mux.sv
// 3:1 operand forward selector: register value, W-stage result or M-stage ALU result.
// Latency: purely combinational.
// Backpressure: none; follows the select every cycle.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] reg_val,
  input  logic [XLEN-1:0] w_val,
  input  logic [XLEN-1:0] m_val,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] fwd_val
);

  // Pick the forwarded source; the unused 2'b11 code keeps the register value
  always_comb begin
    fwd_val = reg_val;
    case (sel)
      FWD_W:   fwd_val = w_val;
      FWD_M:   fwd_val = m_val;
      default: fwd_val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with E-stage operand forwarding, immediate select and branch target add.
// Latency: one clk from D inputs to E registers; operand/target outputs combinational from E state.
// Backpressure: StallE holds every E register; FlushE (or rst) loads a bubble and wins over StallE.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NOP_RD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [4:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [4:0]      ALUControlE,
  output logic [2:0]      funct3E,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [1:0]      ResultSrcE
);

  localparam logic [4:0] NOP_RD_L = NOP_RD[4:0];

  ctrl_t           ctrl_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc_plus4_e;
  logic [XLEN-1:0] imm_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // E-stage registers: reset and flush both load a bubble, stall holds, otherwise capture D
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ctrl_e     <= BUBBLE_CTRL;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      imm_e      <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= NOP_RD_L;
    end else if (!StallE) begin
      ctrl_e     <= '{
        reg_write:   RegWriteD,
        mem_write:   MemWriteD,
        branch:      BranchD,
        jump:        JumpD,
        alu_src:     ALUSrcD,
        result_src:  ResultSrcD,
        alu_control: ALUControlD,
        funct3:      funct3D
      };
      rd1_e      <= RD1D;
      rd2_e      <= RD2D;
      pc_e       <= PCD;
      pc_plus4_e <= PCPlus4D;
      imm_e      <= ImmExtD;
      rs1_e      <= Rs1D;
      rs2_e      <= Rs2D;
      rd_e       <= RdD;
    end
  end

  // x0 suppression is the hazard unit's job, so forwarding follows the selects blindly
  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .reg_val (rd1_e),
    .w_val   (ResultW),
    .m_val   (ALUResultM),
    .sel     (ForwardAE),
    .fwd_val (fwd_a)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .reg_val (rd2_e),
    .w_val   (ResultW),
    .m_val   (ALUResultM),
    .sel     (ForwardBE),
    .fwd_val (fwd_b)
  );

  assign SrcAE      = fwd_a;
  assign SrcBE      = ctrl_e.alu_src ? imm_e : fwd_b;
  assign WriteDataE = fwd_b;
  // Target add wraps at XLEN bits; the carry is dropped
  assign PCTargetE  = pc_e + imm_e;
  assign PCPlus4E   = pc_plus4_e;

  assign Rs1E        = rs1_e;
  assign Rs2E        = rs2_e;
  assign RdE         = rd_e;
  assign ALUControlE = ctrl_e.alu_control;
  assign funct3E     = ctrl_e.funct3;
  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign BranchE     = ctrl_e.branch;
  assign JumpE       = ctrl_e.jump;
  assign ResultSrcE  = ctrl_e.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model feeds a scoreboard queue compared after each edge.
// Latency: expectations are formed at drive time and checked #1 after the capturing edge.
// Backpressure: exercises StallE/FlushE/rst priority and same-cycle forwarding.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD, ALUControlD;
  logic [2:0]  funct3D;
  logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [31:0] ALUResultM, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE, ALUControlE;
  logic [2:0]  funct3E;
  logic        RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .NOP_RD(0)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .funct3D(funct3D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ALUControlE(ALUControlE), .funct3E(funct3E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE)
  );

  typedef struct {
    string       tag;
    logic [31:0] srca, srcb, wd, tgt, pc4;
    logic [4:0]  rs1, rs2, rd, aluc;
    logic [2:0]  f3;
    logic        rw, mw, br, jp;
    logic [1:0]  rs;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference E-stage state
  logic [31:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_aluc;
  logic [2:0]  m_f3;
  logic        m_rw, m_mw, m_br, m_jp, m_alusrc;
  logic [1:0]  m_rs;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r);
    case (sel)
      2'b01:   return ResultW;
      2'b10:   return ALUResultM;
      default: return r;
    endcase
  endfunction

  // Next-state of the reference registers from the inputs present before the edge
  task automatic model_clock();
    if (rst || FlushE) begin
      m_rd1 = 0; m_rd2 = 0; m_pc = 0; m_pc4 = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 5'd0; m_aluc = 5'b00000; m_f3 = 3'b010;
      m_rw = 0; m_mw = 0; m_br = 0; m_jp = 0; m_alusrc = 0; m_rs = 2'b00;
    end else if (!StallE) begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_pc4 = PCPlus4D; m_imm = ImmExtD;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD; m_aluc = ALUControlD; m_f3 = funct3D;
      m_rw = RegWriteD; m_mw = MemWriteD; m_br = BranchD; m_jp = JumpD;
      m_alusrc = ALUSrcD; m_rs = ResultSrcD;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.srca = fwd(ForwardAE, m_rd1);
    e.wd   = fwd(ForwardBE, m_rd2);
    e.srcb = m_alusrc ? m_imm : e.wd;
    e.tgt  = m_pc + m_imm;
    e.pc4  = m_pc4;
    e.rs1 = m_rs1; e.rs2 = m_rs2; e.rd = m_rd; e.aluc = m_aluc; e.f3 = m_f3;
    e.rw = m_rw; e.mw = m_mw; e.br = m_br; e.jp = m_jp; e.rs = m_rs;
    sbq.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    check({e.tag, ".SrcAE"},      SrcAE,      e.srca);
    check({e.tag, ".SrcBE"},      SrcBE,      e.srcb);
    check({e.tag, ".WriteDataE"}, WriteDataE, e.wd);
    check({e.tag, ".PCTargetE"},  PCTargetE,  e.tgt);
    check({e.tag, ".PCPlus4E"},   PCPlus4E,   e.pc4);
    check({e.tag, ".Rs1E"},       32'(Rs1E),  32'(e.rs1));
    check({e.tag, ".Rs2E"},       32'(Rs2E),  32'(e.rs2));
    check({e.tag, ".RdE"},        32'(RdE),   32'(e.rd));
    check({e.tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.aluc));
    check({e.tag, ".funct3E"},    32'(funct3E), 32'(e.f3));
    check({e.tag, ".ctrl"}, {27'd0, RegWriteE, MemWriteE, BranchE, JumpE, 1'b0},
                            {27'd0, e.rw, e.mw, e.br, e.jp, 1'b0});
    check({e.tag, ".ResultSrcE"}, 32'(ResultSrcE), 32'(e.rs));
  endtask

  // One capturing edge: model, queue expectation, clock, compare
  task automatic step(input string tag);
    model_clock();
    push_exp(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Same-cycle recheck after changing only M/W/forward inputs
  task automatic comb_check(input string tag);
    #1;
    push_exp(tag);
    check_out();
  endtask

  initial begin
    rst = 1; StallE = 0; FlushE = 0;
    RD1D = 32'hdead; RD2D = 32'hbeef; PCD = 32'h40; PCPlus4D = 32'h44; ImmExtD = 32'h8;
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd9; ALUControlD = 5'd2; funct3D = 3'd1;
    RegWriteD = 1; MemWriteD = 1; BranchD = 1; JumpD = 1; ALUSrcD = 0; ResultSrcD = 2'b01;
    ALUResultM = 0; ResultW = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    @(negedge clk);
    step("reset");
    check("reset_srca", SrcAE, 32'h0);
    check("reset_f3", 32'(funct3E), 32'h2);

    // Basic capture
    rst = 0;
    RD1D = 5; RD2D = 7; ALUSrcD = 0; RegWriteD = 1; MemWriteD = 0; BranchD = 0; JumpD = 0;
    step("capture");
    check("cap_srca", SrcAE, 32'd5);
    check("cap_srcb", SrcBE, 32'd7);
    check("cap_wd", WriteDataE, 32'd7);

    // Same-cycle forwarding from M and W
    ALUResultM = 32'h100; ForwardAE = 2'b10; ResultW = 32'h55; ForwardBE = 2'b01;
    comb_check("fwd_mw");
    check("fwd_srca", SrcAE, 32'h100);
    check("fwd_srcb", SrcBE, 32'h55);
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    comb_check("fwd_11");
    check("fwd11_srca", SrcAE, 32'd5);

    // Immediate operand vs forwarded store data
    ForwardAE = 2'b00; ForwardBE = 2'b10; ALUResultM = 32'd3;
    ALUSrcD = 1; ImmExtD = 32'hFFFF_FFFC; RD2D = 9;
    step("imm");
    check("imm_srcb", SrcBE, 32'hFFFF_FFFC);
    check("imm_wd", WriteDataE, 32'd3);

    // Branch target wraps past 2^32
    ForwardBE = 2'b00; PCD = 32'hFFFF_FFF8; ImmExtD = 32'h10;
    step("tgt_wrap");
    check("tgt_wrap", PCTargetE, 32'h8);

    // Stall with moving D inputs
    RegWriteD = 1; RdD = 5'd7; RD1D = 32'h11; PCD = 32'h200;
    step("pre_stall");
    StallE = 1;
    RD1D = 32'h22; RdD = 5'd12; RegWriteD = 0; PCD = 32'h300;
    step("stall1");
    RD1D = 32'h33; RdD = 5'd13; ImmExtD = 32'h4;
    step("stall2");
    check("stall_rd", 32'(RdE), 32'd7);
    check("stall_srca", SrcAE, 32'h11);

    // Flush beats stall
    FlushE = 1;
    step("stall_flush");
    check("flush_rw", 32'(RegWriteE), 32'd0);
    check("flush_rd", 32'(RdE), 32'd0);

    // Reset while stalled discards held state
    FlushE = 0; StallE = 0; RegWriteD = 1; MemWriteD = 1; RD1D = 32'h77; RD2D = 32'h88;
    step("pre_rst");
    StallE = 1; rst = 1;
    step("rst_stall");
    check("rst_rw", 32'(RegWriteE), 32'd0);
    check("rst_wd", WriteDataE, 32'd0);
    rst = 0; StallE = 0;

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      ALUControlD = 5'($urandom); funct3D = 3'($urandom);
      {RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD} = 5'($urandom);
      ResultSrcD = 2'($urandom);
      ALUResultM = $urandom; ResultW = $urandom;
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 5) == 0);
      rst    = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NOP_RD, default 0, destination register loaded on bubble/reset.
REQ-003 SHALL have clk input 1, the single rising-edge clock.
REQ-004 SHALL have rst input 1, synchronous active-high reset.
REQ-005 SHALL have StallE input 1, hold all E-stage registers.
REQ-006 SHALL have FlushE input 1, load a bubble into the E stage.
REQ-007 SHALL have RD1D, RD2D input XLEN each, register-file read data.
REQ-008 SHALL have PCD, PCPlus4D, ImmExtD input XLEN each, decode PC, PC+4 and extended immediate.
REQ-009 SHALL have Rs1D, Rs2D, RdD input 5 each, register addresses.
REQ-010 SHALL have ALUControlD input 5 and funct3D input 3, ALU operation and branch condition.
REQ-011 SHALL have RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD input 1 each, and ResultSrcD input 2, decode control.
REQ-012 SHALL have ALUResultM, ResultW input XLEN each, forwarding sources.
REQ-013 SHALL have ForwardAE, ForwardBE input 2 each, hazard-unit forward selects.
REQ-014 SHALL have SrcAE, SrcBE output XLEN each, ALU operands.
REQ-015 SHALL have WriteDataE, PCTargetE, PCPlus4E output XLEN each, store data, branch/jump target, link value.
REQ-016 SHALL have Rs1E, Rs2E, RdE output 5 each, and ALUControlE 5, funct3E 3, RegWriteE, MemWriteE, BranchE, JumpE 1 each, ResultSrcE 2, registered fields.

Function
REQ-017 SHALL capture all D-side inputs into E registers on each rising clk when rst=0, StallE=0, FlushE=0 (latency one cycle).
REQ-018 SHALL hold every E register unchanged when StallE=1 and FlushE=0.
REQ-019 SHALL load a bubble when FlushE=1, regardless of StallE: RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE=0, ResultSrcE=0, ALUControlE=5'b00000, funct3E=3'b010 (no branch condition), Rs1E=Rs2E=0, RdE=NOP_RD; data registers zero.
REQ-020 SHALL compute forwarded A: ForwardAE 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E.
REQ-021 SHALL compute forwarded B identically from RD2E with ForwardBE; WriteDataE SHALL equal forwarded B.
REQ-022 SHALL drive SrcAE = forwarded A; SrcBE = ImmExtE when ALUSrcE=1, else forwarded B.
REQ-023 SHALL drive PCTargetE = PCE + ImmExtE, modulo 2^XLEN, carry discarded.
REQ-024 SHALL make forwarding and operand outputs purely combinational from current E registers and M/W inputs (same-cycle).
REQ-025 SHALL forward even when Rs1E/Rs2E = 0 if so selected; suppressing x0 forwarding is the hazard unit's duty.

Reset
REQ-026 SHALL, on rising clk with rst=1, load the bubble of REQ-019; rst SHALL override StallE and FlushE.
REQ-027 SHALL, after reset, present SrcAE=SrcBE=0, PCTargetE=0, PCPlus4E=0 until first capture with ForwardAE/BE=00.
REQ-028 SHALL, on reset asserted mid-stall, discard held contents; no state survives reset.

Structure
REQ-029 SHALL take from shared package riscv_pkg: ALU control encodings, forward-select enum (FWD_REG=00, FWD_W=01, FWD_M=10), ResultSrc encodings, bubble constants.
REQ-030 SHALL instantiate sub-module fwd_mux (3:1 forward selector) twice, for A and B.
REQ-031 SHALL implement registers in a single sequential process with priority rst > FlushE > StallE > capture.

Verification
REQ-032 Capture: RD1D=5, RD2D=7, ALUSrcD=0, fwd 00, one clk -> SrcAE=5, SrcBE=7, WriteDataE=7.
REQ-033 Forward: RD1E=5, ALUResultM=0x100, ForwardAE=10; ResultW=0x55, ForwardBE=01 -> SrcAE=0x100, SrcBE=0x55, same cycle.
REQ-034 Immediate: ALUSrcD=1, ImmExtD=0xFFFFFFFC, RD2D=9, ForwardBE=10, ALUResultM=3 -> SrcBE=0xFFFFFFFC, WriteDataE=3.
REQ-035 Target wrap: PCD=0xFFFFFFF8, ImmExtD=0x10 -> PCTargetE=0x00000008.
REQ-036 Stall/flush: StallE=1 two cycles with changing D inputs -> E outputs constant; StallE=1 and FlushE=1 -> RegWriteE=0, MemWriteE=0, RdE=0.
REQ-037 Reset: rst=1 during StallE=1 with RegWriteE=1 -> next clk RegWriteE=0, all data outputs 0.
